// File: rtl/sha_digest_uart_tx.sv
// Serialises a 256-bit SHA-256 digest onto a UART 8N1 line, byte 0 first.
// Define SHA_DIGEST_HEX_EN to send 64 lowercase hex digits plus CR LF instead of 32 raw bytes.
module sha_digest_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] i_digest,
  input  logic         i_digest_valid,
  output logic         o_digest_ready,
  output logic         o_uart_tx,
  output logic         o_tx_busy,
  output logic         o_done
);

  localparam int unsigned DIG_W  = 256;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 7;
`ifdef SHA_DIGEST_HEX_EN
  localparam int unsigned NUM_CHARS = 66;
  localparam int unsigned SHIFT_W   = 4;
`else
  localparam int unsigned NUM_CHARS = 32;
  localparam int unsigned SHIFT_W   = 8;
`endif

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] CHAR_LAST = IDX_W'(NUM_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]    char_idx_q, char_idx_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [CHAR_W-1:0]   sh_q, sh_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
  logic                load;

`ifdef SHA_DIGEST_HEX_EN
  // Top nibble of the remaining digest as ASCII, with CR/LF appended after the digits.
  function automatic logic [CHAR_W-1:0] hex_char(input logic [DIG_W-1:0] dig,
                                                 input logic [IDX_W-1:0] idx);
    logic [3:0] nib;
    nib = dig[DIG_W-1 -: 4];
    if (idx == IDX_W'(64)) return 8'h0D;
    if (idx == IDX_W'(65)) return 8'h0A;
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h57 + {4'h0, nib};
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    dig_d      = dig_q;
    sh_d       = sh_q;
    load       = 1'b0;
    bit_end    = (cnt_q == BIT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (i_digest_valid && ready_q) begin
          state_d    = S_START;
          dig_d      = i_digest;
          char_idx_d = '0;
          cnt_d      = '0;
          load       = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            sh_d      = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Character counter never wraps: the last stop bit always ends the transfer.
          if (char_idx_q == CHAR_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_START;
            char_idx_d = char_idx_q + IDX_W'(1);
            dig_d      = dig_q << SHIFT_W;
            load       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SHA_DIGEST_HEX_EN
    if (load) sh_d = hex_char(dig_d, char_idx_d);
`else
    if (load) sh_d = dig_d[DIG_W-1 -: CHAR_W];
`endif

    // Outputs are registered, so they are derived from the next state.
    tx_d    = 1'b1;
    if (state_d == S_START) tx_d = 1'b0;
    if (state_d == S_DATA)  tx_d = sh_d[0];
    busy_d  = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      dig_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      dig_q      <= dig_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_uart_tx      = tx_q;
  assign o_digest_ready = ready_q;
  assign o_tx_busy      = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_sha_digest_uart_tx.sv
// Bench for sha_digest_uart_tx: per-cycle line/handshake checks against a frame-level model.
module tb_sha_digest_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;
`ifdef SHA_DIGEST_HEX_EN
  localparam int unsigned N = 66;
`else
  localparam int unsigned N = 32;
`endif
  localparam logic [255:0] D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] i_digest;
  logic         i_digest_valid;
  logic         o_digest_ready;
  logic         o_uart_tx;
  logic         o_tx_busy;
  logic         o_done;

  int checks     = 0;
  int errors     = 0;
  int done_total = 0;
  int done_exp   = 0;

  sha_digest_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_digest       (i_digest),
    .i_digest_valid (i_digest_valid),
    .o_digest_ready (o_digest_ready),
    .o_uart_tx      (o_uart_tx),
    .o_tx_busy      (o_tx_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done === 1'b1) done_total++;

  // Character i of the transmitted stream for digest d.
  function automatic logic [7:0] exp_char(input logic [255:0] d, input int i);
`ifdef SHA_DIGEST_HEX_EN
    string hx;
    int    nib;
    hx = "0123456789abcdef";
    if (i == 64) return 8'h0D;
    if (i == 65) return 8'h0A;
    nib = int'((d >> (4 * (63 - i))) & 256'hF);
    return hx[nib];
`else
    return 8'((d >> (8 * (31 - i))) & 256'hFF);
`endif
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [3:0] outs();
    return {o_uart_tx, o_tx_busy, o_digest_ready, o_done};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed {tx,busy,ready,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present a digest with a one-cycle valid pulse; returns at the first start-bit cycle.
  task automatic start(input logic [255:0] d);
    i_digest       = d;
    i_digest_valid = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the first start-bit cycle; checks every cycle of the transfer, DONE and the idle cycle.
  task automatic run_stream(input logic [255:0] d, input int disturb_at, input int abort_at,
                            input bit hold_valid);
    int          f;
    int          b;
    logic [7:0]  c;
    logic        e;
    for (int k = 0; k < int'(N * FRAME); k++) begin
      if (k == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mid_frame", outs(), 4'b1010);
        rst = 1'b1;
        return;
      end
      if (!hold_valid) i_digest_valid = (k == disturb_at);
      if (k == disturb_at) i_digest = rand256();
      f = k / int'(FRAME);
      b = (k % int'(FRAME)) / int'(CPB);
      c = exp_char(d, f);
      if (b == 0)      e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = c[b-1];
      chk($sformatf("stream char%0d bit%0d", f, b), outs(), {e, 3'b100});
      @(negedge clk);
    end
    chk("done_cycle", outs(), 4'b1001);
    done_exp++;
    @(negedge clk);
    chk("idle_after_done", outs(), 4'b1010);
  endtask

  initial begin
    logic [255:0] r;
    rst            = 1'b0;
    i_digest       = '0;
    i_digest_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", outs(), 4'b1010);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", outs(), 4'b1010);

    // Reference digest, one-cycle valid pulse
    start(D);
    run_stream(D, -1, -1, 1'b0);

    // Random digest
    r = rand256();
    @(negedge clk);
    start(r);
    run_stream(r, -1, -1, 1'b0);

    // Valid held high across DONE, second digest all zeros
    @(negedge clk);
    i_digest       = D;
    i_digest_valid = 1'b1;
    @(negedge clk);
    i_digest = '0;
    run_stream(D, -1, -1, 1'b1);
    @(negedge clk);
    run_stream('0, -1, -1, 1'b0);

    // Digest changed and valid pulsed during character 5
    @(negedge clk);
    start(D);
    run_stream(D, 5 * int'(FRAME) + 3 * int'(CPB), -1, 1'b0);

    // Reset during the data bits of character 10, then a fresh full digest
    r = rand256();
    @(negedge clk);
    start(r);
    run_stream(r, -1, 10 * int'(FRAME) + 2 * int'(CPB), 1'b0);
    for (int k = 0; k < int'(3 * FRAME); k++) begin
      @(negedge clk);
      chk("idle_after_abort", outs(), 4'b1010);
    end
    r = rand256();
    start(r);
    run_stream(r, -1, -1, 1'b0);

    // Reset on the same edge as a valid handshake
    rst            = 1'b0;
    i_digest       = rand256();
    i_digest_valid = 1'b1;
    @(negedge clk);
    chk("reset_vs_valid", outs(), 4'b1010);
    rst            = 1'b1;
    i_digest_valid = 1'b0;
    for (int k = 0; k < int'(2 * CPB + 2); k++) begin
      @(negedge clk);
      chk("line_idle_after_reset_valid", outs(), 4'b1010);
    end

    checks++;
    assert (done_total === done_exp) else begin
      errors++;
      $error("FAIL done_pulse_count observed=%0d expected=%0d", done_total, done_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
